// File: rtl/fp_align_stage.sv
// rtl/fp_align_stage.sv - FP adder operand alignment stage with 2-entry output buffer
module fp_align_stage #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    Clk,
  input  logic                    Clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   A,
  input  logic [EXP_W+FRAC_W:0]   B,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign_big,
  output logic                    eff_sub,
  output logic [EXP_W-1:0]        exp_out,
  output logic [FRAC_W:0]         mant_big,
  output logic [FRAC_W+3:0]       mant_small,
  output logic                    is_nan,
  output logic                    is_inf
);

  localparam int SIG_W = FRAC_W + 1;
  localparam int MS_W  = SIG_W + 3;
  localparam int ENT_W = 2 + EXP_W + SIG_W + MS_W + 2;
  localparam int MAG_W = EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(MS_W);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Operand fields
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [EXP_W-1:0]  eff_a, eff_b;
  logic [SIG_W-1:0]  sig_a, sig_b;

  assign exp_a  = A[MAG_W-1:FRAC_W];
  assign exp_b  = B[MAG_W-1:FRAC_W];
  assign frac_a = A[FRAC_W-1:0];
  assign frac_b = B[FRAC_W-1:0];

  // Denormals share the exponent of the smallest normal; hidden bit only for normals
  assign eff_a = (exp_a == '0) ? EXP_ONE : exp_a;
  assign eff_b = (exp_b == '0) ? EXP_ONE : exp_b;
  assign sig_a = {exp_a != '0, frac_a};
  assign sig_b = {exp_b != '0, frac_b};

  // Magnitude ordering: sign excluded, ties keep A as the big operand
  logic             swap;
  logic             sign_big_c;
  logic [EXP_W-1:0] eff_big, eff_small;
  logic [SIG_W-1:0] sig_big, sig_small;

  assign swap       = A[MAG_W-1:0] < B[MAG_W-1:0];
  assign sign_big_c = swap ? B[MAG_W] : A[MAG_W];
  assign eff_big    = swap ? eff_b : eff_a;
  assign eff_small  = swap ? eff_a : eff_b;
  assign sig_big    = swap ? sig_b : sig_a;
  assign sig_small  = swap ? sig_a : sig_b;

  // Right-shift the small significand, folding every lost bit into sticky
  logic [EXP_W-1:0] shift_d;
  logic [MS_W-1:0]  x_ext;
  logic [MS_W-1:0]  x_shifted;
  logic [MS_W-1:0]  x_lost;
  logic [MS_W-1:0]  mant_small_c;

  assign shift_d = eff_big - eff_small;
  assign x_ext   = {sig_small, 3'b000};

  // Alignment shifter with sticky collapse for shifts past the whole field
  always_comb begin
    x_shifted    = x_ext >> shift_d;
    x_lost       = x_ext & ~({MS_W{1'b1}} << shift_d);
    mant_small_c = '0;
    if (shift_d < SHIFT_LIM) begin
      mant_small_c = {x_shifted[MS_W-1:1], x_shifted[0] | (|x_lost)};
    end else begin
      mant_small_c = {{(MS_W-1){1'b0}}, |sig_small};
    end
  end

  // Special-value detection; alignment fields are left as computed
  logic nan_a, nan_b, inf_a, inf_b;
  logic is_nan_c, is_inf_c;

  assign nan_a    = (exp_a == EXP_ALL1) && (frac_a != '0);
  assign nan_b    = (exp_b == EXP_ALL1) && (frac_b != '0);
  assign inf_a    = (exp_a == EXP_ALL1) && (frac_a == '0);
  assign inf_b    = (exp_b == EXP_ALL1) && (frac_b == '0);
  assign is_nan_c = nan_a || nan_b || (inf_a && inf_b && (A[MAG_W] != B[MAG_W]));
  assign is_inf_c = !is_nan_c && (inf_a || inf_b);

  logic [ENT_W-1:0] new_entry;

  assign new_entry = {sign_big_c, A[MAG_W] ^ B[MAG_W], eff_big, sig_big,
                      mant_small_c, is_nan_c, is_inf_c};

  // Two-entry buffer: head drives the outputs, tail only holds overflow
  logic [1:0]       count;
  logic [ENT_W-1:0] head, tail;
  logic             accept, pop;

  assign in_ready  = (count != ST_TWO);
  assign out_valid = (count != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Buffer occupancy and entry movement; emptied slots are zeroed
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      count <= ST_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        ST_EMPTY: begin
          if (accept) begin
            head  <= new_entry;
            count <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head <= new_entry;
          end else if (accept) begin
            tail  <= new_entry;
            count <= ST_TWO;
          end else if (pop) begin
            head  <= '0;
            count <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head  <= tail;
            tail  <= '0;
            count <= ST_ONE;
          end
        end
        default: begin
          count <= ST_EMPTY;
          head  <= '0;
          tail  <= '0;
        end
      endcase
    end
  end

  assign {sign_big, eff_sub, exp_out, mant_big, mant_small, is_nan, is_inf} = head;

endmodule
